// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync/blank strobes, active coordinates,
// lookahead pixel request and frame/line pulses. Optional colour-bar pattern under VGA_TIMING_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 13,
  parameter int REQ_LEAD = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             pattern_sel_i,
  output logic             hs_no,
  output logic             vs_no,
  output logic             blank_no,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             req_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic [7:0]       pat_R_o,
  output logic [7:0]       pat_G_o,
  output logic [7:0]       pat_B_o
);

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_EOL    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  // REQ_LEAD < H_TOTAL, so advancing (0, V_ACTIVE) never carries into v
  localparam logic [CNT_W-1:0] HQ_RST   = CNT_W'(REQ_LEAD);
  localparam logic             HS_ACT   = 1'(HS_POL);
  localparam logic             VS_ACT   = 1'(VS_POL);

  logic [CNT_W-1:0] h_r, v_r, hq_r, vq_r;
  logic [CNT_W-1:0] h_nxt_s, v_nxt_s, hq_nxt_s, vq_nxt_s;
  logic             active_s, req_s, hs_s, vs_s, sof_s, eol_s;
  logic [7:0]       pat_r_s, pat_g_s, pat_b_s;

  // Next position of the raster counter pair
  always_comb begin
    h_nxt_s = h_r + ONE;
    v_nxt_s = v_r;
    if (h_r == H_LAST) begin
      h_nxt_s = ZERO;
      if (v_r == V_LAST) begin
        v_nxt_s = ZERO;
      end else begin
        v_nxt_s = v_r + ONE;
      end
    end else begin
      h_nxt_s = h_r + ONE;
    end
  end

  // Next position of the lookahead counter pair, running REQ_LEAD clocks ahead
  always_comb begin
    hq_nxt_s = hq_r + ONE;
    vq_nxt_s = vq_r;
    if (hq_r == H_LAST) begin
      hq_nxt_s = ZERO;
      if (vq_r == V_LAST) begin
        vq_nxt_s = ZERO;
      end else begin
        vq_nxt_s = vq_r + ONE;
      end
    end else begin
      hq_nxt_s = hq_r + ONE;
    end
  end

  // Counter registers; reset parks the raster at the start of vertical front porch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_r  <= ZERO;
      v_r  <= V_ACT;
      hq_r <= HQ_RST;
      vq_r <= V_ACT;
    end else if (en_i) begin
      h_r  <= h_nxt_s;
      v_r  <= v_nxt_s;
      hq_r <= hq_nxt_s;
      vq_r <= vq_nxt_s;
    end
  end

  // Strobe decodes of the current counter state
  always_comb begin
    active_s = (h_r < H_ACT) && (v_r < V_ACT);
    req_s    = (hq_r < H_ACT) && (vq_r < V_ACT);
    hs_s     = ((h_r >= HS_START) && (h_r < HS_END)) ? HS_ACT : ~HS_ACT;
    vs_s     = ((v_r >= VS_START) && (v_r < VS_END)) ? VS_ACT : ~VS_ACT;
    sof_s    = (h_r == ZERO) && (v_r == ZERO);
    eol_s    = (h_r == H_EOL) && (v_r < V_ACT);
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam int               BAR_W_I = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_W   = CNT_W'(BAR_W_I);
  localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(7);
  logic [CNT_W-1:0] bar_raw_s;
  logic [2:0]       bar_s;

  // Colour bars: bar index bits pick which channels drop out (white..black order)
  always_comb begin
    bar_raw_s = h_r / BAR_W;
    if (bar_raw_s > BAR_MAX) begin
      bar_s = 3'd7;
    end else begin
      bar_s = bar_raw_s[2:0];
    end
    if (active_s && pattern_sel_i) begin
      pat_r_s = bar_s[1] ? 8'h00 : 8'hFF;
      pat_g_s = bar_s[2] ? 8'h00 : 8'hFF;
      pat_b_s = bar_s[0] ? 8'h00 : 8'hFF;
    end else begin
      pat_r_s = 8'h00;
      pat_g_s = 8'h00;
      pat_b_s = 8'h00;
    end
  end
`else
  logic unused_pattern_sel_s;
  assign unused_pattern_sel_s = pattern_sel_i;

  // Pattern disabled: colour outputs are constant black
  always_comb begin
    pat_r_s = 8'h00;
    pat_g_s = 8'h00;
    pat_b_s = 8'h00;
  end
`endif

  // Output registers; all share the same one-clock latency from the counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_no    <= ~HS_ACT;
      vs_no    <= ~VS_ACT;
      blank_no <= 1'b0;
      col_o    <= ZERO;
      row_o    <= ZERO;
      req_o    <= 1'b0;
      sof_o    <= 1'b0;
      eol_o    <= 1'b0;
      pat_R_o  <= 8'h00;
      pat_G_o  <= 8'h00;
      pat_B_o  <= 8'h00;
    end else if (en_i) begin
      hs_no    <= hs_s;
      vs_no    <= vs_s;
      blank_no <= active_s;
      col_o    <= active_s ? h_r : ZERO;
      row_o    <= active_s ? v_r : ZERO;
      req_o    <= req_s;
      sof_o    <= sof_s;
      eol_o    <= eol_s;
      pat_R_o  <= pat_r_s;
      pat_G_o  <= pat_g_s;
      pat_B_o  <= pat_b_s;
    end
  end

endmodule
